// File: rtl/calculator_pkg.sv
// Shared constants, opcode/state encodings and a widening helper for the calculator core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calculator_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic [RES_W-1:0] DIV0_RESULT = 16'hFFFF;

  typedef enum logic [1:0] {
    FN_ADD = 2'b00,
    FN_SUB = 2'b01,
    FN_MUL = 2'b10,
    FN_DIV = 2'b11
  } calc_func_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } calc_state_e;

  // Zero-extend an operand to result width.
  function automatic logic [RES_W-1:0] zext(input logic [DATA_W-1:0] v);
    return {{(RES_W-DATA_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/calculator_iter_unit.sv
// Shared iterative datapath: shift-add multiplier and restoring divider, one step per cycle.
// Latency: DATA_W cycles from start; done flags the cycle performing the last step.
// Backpressure: none; the caller registers result on the done cycle.
module calculator_iter_unit
  import calculator_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [RES_W-1:0]  result
);

  logic              busy;
  logic              div_sel;
  logic [CNT_W-1:0]  cnt;
  // MUL: product accumulator. DIV: partial remainder in the low DATA_W+1 bits.
  logic [RES_W-1:0]  acc;
  logic [RES_W-1:0]  mcand;
  // MUL: multiplier shifting right. DIV: divisor, held constant.
  logic [DATA_W-1:0] mplier;
  // DIV: dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [DATA_W-1:0] quot;

  logic [RES_W-1:0]  acc_nxt;
  logic [RES_W-1:0]  mcand_nxt;
  logic [DATA_W-1:0] mplier_nxt;
  logic [DATA_W-1:0] quot_nxt;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   trial;

  // One iteration of whichever operation is in flight.
  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    quot_nxt   = quot;
    rem_sh     = '0;
    trial      = '0;
    if (div_sel) begin
      rem_sh = {acc[DATA_W-1:0], quot[DATA_W-1]};
      trial  = rem_sh - {1'b0, mplier};
      if (!trial[DATA_W]) begin
        acc_nxt  = {{(RES_W-DATA_W-1){1'b0}}, trial};
        quot_nxt = {quot[DATA_W-2:0], 1'b1};
      end else begin
        acc_nxt  = {{(RES_W-DATA_W-1){1'b0}}, rem_sh};
        quot_nxt = {quot[DATA_W-2:0], 1'b0};
      end
    end else begin
      if (mplier[0]) begin
        acc_nxt = acc + mcand;
      end
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
    end
  end

  assign done   = busy && (cnt == '0);
  assign result = div_sel ? {acc_nxt[DATA_W-1:0], quot_nxt} : acc_nxt;

  // Load operands on start, then step and count down until the final iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      div_sel <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      quot    <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      div_sel <= op_div;
      cnt     <= CNT_W'(DATA_W - 1);
      acc     <= '0;
      mcand   <= zext(a);
      mplier  <= b;
      quot    <= a;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      quot   <= quot_nxt;
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/calculator_seq_core.sv
// Calculator engine: ADD/SUB in one cycle, MUL/DIV iterate DATA_W cycles, valid/ready on both sides.
// Latency: 1 cycle ADD/SUB/DIV-by-zero, DATA_W cycles MUL/DIV.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module calculator_seq_core
  import calculator_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dat_a_in,
  input  logic [DATA_W-1:0] dat_b_in,
  input  logic [1:0]        function_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out,
  output logic              err
);

  calc_state_e      state;
  calc_func_e       func;
  logic             accept;
  logic             b_zero;
  logic             iter_start;
  logic             iter_done;
  logic [RES_W-1:0] iter_result;

  assign func       = calc_func_e'(function_in);
  assign accept     = in_valid && in_ready;
  assign b_zero     = (dat_b_in == '0);
  assign iter_start = accept && ((func == FN_MUL) || ((func == FN_DIV) && !b_zero));

  calculator_iter_unit u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .op_div (func == FN_DIV),
    .a      (dat_a_in),
    .b      (dat_b_in),
    .done   (iter_done),
    .result (iter_result)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            case (func)
              FN_ADD: begin
                out       <= zext(dat_a_in) + zext(dat_b_in);
                err       <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
              end
              FN_SUB: begin
                out       <= zext(dat_a_in) - zext(dat_b_in);
                err       <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
              end
              FN_MUL: begin
                state <= CALC;
              end
              FN_DIV: begin
                if (b_zero) begin
                  out       <= DIV0_RESULT;
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
                end else begin
                  state <= CALC;
                end
              end
            endcase
          end
        end
        CALC: begin
          if (iter_done) begin
            out       <= iter_result;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/calculator_seq_core.md
Name: calculator_seq_core

Overview:
Arithmetic engine that consumes the calculator operand/function bus (dat_a_in, dat_b_in, function_in) and produces the 16-bit result bus (out).
- Adds a valid/ready handshake on both sides.
- ADD/SUB complete in one cycle; MUL uses an iterative shift-add datapath, DIV a restoring divider.
- Sits directly between the stimulus/driver side of the calculator interface and the result consumer (monitor/scoreboard or downstream logic).

Parameters:
DATA_W, 8, operand width.
RES_W, 16, result width; fixed at 2*DATA_W.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands and function are valid.
in_ready  output  1  core can accept an operation; high only in IDLE.
dat_a_in  input  DATA_W  operand A, unsigned.
dat_b_in  input  DATA_W  operand B, unsigned.
function_in  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
out_valid  output  1  result valid; held until consumed.
out_ready  input  1  consumer accepts the result.
out  output  RES_W  result.
err  output  1  qualified by out_valid; set only for divide-by-zero.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; out=0, out_valid=0, err=0.
  - Iteration counter and operand registers cleared.
  - in_ready=1 in the first cycle after release.
- FSM states: IDLE, CALC, DONE.
- Accept: on a clock edge where in_valid && in_ready, the core latches dat_a_in, dat_b_in and function_in. It ignores the inputs in every other cycle.
- Transitions out of IDLE on accept:
  - ADD/SUB → DONE, with the result registered on the same edge. out_valid goes high 1 cycle after accept.
  - DIV with B==0 → DONE, out=16'hFFFF, err=1, latency 1 cycle.
  - MUL, or DIV with B!=0 → CALC, counter loaded with DATA_W-1.
- CALC:
  - One iteration per cycle; counter decrements.
  - When counter==0, the final iteration completes and the FSM moves to DONE.
  - out_valid goes high exactly DATA_W cycles after the accept edge (8 for defaults).
- DONE:
  - out_valid=1; out and err stable.
  - If out_ready is high on an edge → IDLE, out_valid=0. out keeps its last value, with no significance while out_valid is low.
  - No new operation is accepted in DONE, even if out_ready and in_valid are high together. Minimum spacing between operations is therefore 2 cycles.
- Arithmetic (operands zero-extended to RES_W):
  - ADD: out = A+B (max 0x01FE, no overflow).
  - SUB: out = (A-B) mod 2^RES_W, two's-complement wrap.
  - MUL: unsigned product.
    - Accumulator starts at 0.
    - Each iteration: if multiplier LSB is 1, add the shifted multiplicand; then shift the multiplicand left 1 and the multiplier right 1.
  - DIV: restoring algorithm, with a DATA_W+1-bit partial remainder.
    - Each iteration: shift in the dividend MSB, then trial-subtract B.
    - If the trial result is non-negative, keep it and set the quotient bit to 1.
    - Result: out = {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}.
- err is 0 for every operation except divide-by-zero.
- Reset asserted mid-CALC or in DONE: the operation is aborted and the result discarded; every output returns to its reset value immediately (async).
- function_in/operand changes while busy have no effect.

Decomposition:
- Package calculator_pkg:
  - DATA_W/RES_W constants.
  - Enum calc_func_e: FN_ADD=2'b00, FN_SUB=2'b01, FN_MUL=2'b10, FN_DIV=2'b11.
  - Enum calc_state_e: IDLE, CALC, DONE.
  - Constant DIV0_RESULT=16'hFFFF.
- One sub-module, calculator_iter_unit:
  - Holds the shared MUL/DIV iteration datapath: accumulator/remainder, shift registers, counter.
  - Controls: start, op select, done.
- The FSM and handshake stay in the top.

Test Plan:
- ADD A=200, B=100, out_ready=1 → out_valid 1 cycle after accept, out=0x012C, err=0, in_ready back high on the following cycle.
- SUB A=5, B=10 → out=0xFFFB after 1 cycle; then SUB A=10, B=5 → out=0x0005.
- MUL A=255, B=255 → out_valid exactly 8 cycles after accept, out=0xFE01; in_ready low throughout CALC/DONE.
- DIV A=200, B=7 → out=0x041C (q=28, r=4) after 8 cycles; DIV A=9, B=0 → out=0xFFFF, err=1 after 1 cycle.
- Backpressure: MUL A=3, B=4 with out_ready low for 5 cycles after out_valid → out=0x000C held stable, in_valid pulses ignored; one out_ready cycle → IDLE.
- Reset mid-op: assert rst 3 cycles into MUL A=17, B=19 → out_valid=0, out=0 immediately. After release, ADD A=1, B=1 → out=0x0002 with no residue from the aborted op.
